psum_binarizer: RTL and testbench

- Sits directly downstream of the BNN PE array and consumes its per-output-channel partial sums, which arrive serially, one channel per cycle.
- Compares each psum against a per-channel threshold (folded batch-norm) to produce one activation bit.
- Packs O_CH bits into one binary activation word and buffers words in a small FIFO.
- Hands words to the next-layer loader over a valid/ready handshake.

---
 rtl/psum_binarizer.sv | 128 ++++++++++++
 tb/tb_psum_binarizer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/psum_binarizer.sv
// psum_binarizer: turns serial per-channel partial sums into packed binary
// activation words. Each psum is compared against a per-channel threshold.
// O_CH result bits form one word, and the words wait in a small FIFO until
// the next-layer loader takes them over a valid/ready handshake.

module psum_binarizer_lane #(
  parameter int WIDTH = 14
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    ld,
  input  logic signed [WIDTH-1:0] thr_data,
  input  logic signed [WIDTH-1:0] psum,
  output logic                    ge
);
  logic signed [WIDTH-1:0] thr;

  // Per-channel threshold register (folded batch-norm), written by the load port
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)  thr <= '0;
    else if (ld)  thr <= thr_data;
  end

  // Full-width signed compare; equality yields 1. This uses the registered
  // threshold, so a load in the same cycle takes effect only on the next word.
  assign ge = (psum >= thr);
endmodule

module psum_binarizer #(
  parameter int WIDTH      = 14,
  parameter int O_CH       = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             psum_valid_in,
  input  logic [WIDTH-1:0] psum_in,
  input  logic             frame_clr_in,
  input  logic             thr_load_in,
  input  logic [WIDTH-1:0] thr_data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [O_CH-1:0]  out_bits,
  output logic             overflow_out
);
  localparam int CW = (O_CH > 1) ? $clog2(O_CH) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [CW-1:0]                    ch_cnt, thr_ptr;
  logic [O_CH-1:0]                  ge, partial, word;
  logic                             cur_bit, last, push, pop, full, wr_en, drop;
  logic [FIFO_DEPTH-1:0][O_CH-1:0]  mem;
  logic [PW-1:0]                    wr_ptr, rd_ptr;
  logic [PW:0]                      count;

  // One threshold/compare lane per output channel
  for (genvar c = 0; c < O_CH; c++) begin : g_lane
    psum_binarizer_lane #(.WIDTH(WIDTH)) u_lane (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .ld       (thr_load_in && (thr_ptr == CW'(c))),
      .thr_data (thr_data_in),
      .psum     (psum_in),
      .ge       (ge[c])
    );
  end

  assign cur_bit = ge[ch_cnt];
  assign last    = (ch_cnt == CW'(O_CH - 1));
  assign push    = psum_valid_in && !frame_clr_in && last;
  // The last channel's bit bypasses the partial register so the word leaves on the same edge
  assign word    = {cur_bit, partial[O_CH-2:0]};

  assign out_valid = (count != '0);
  assign out_bits  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign full      = (count == (PW+1)'(FIFO_DEPTH));
  // When the FIFO is full, a same-cycle pop frees the slot the incoming word takes
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;

  // Threshold write pointer, wraps after the last channel
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)          thr_ptr <= '0;
    else if (thr_load_in) thr_ptr <= (thr_ptr == CW'(O_CH - 1)) ? '0 : thr_ptr + 1'b1;
  end

  // Channel counter and partial word; frame clear beats a same-cycle psum
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ch_cnt  <= '0;
      partial <= '0;
    end else if (frame_clr_in) begin
      ch_cnt  <= '0;
      partial <= '0;
    end else if (psum_valid_in) begin
      partial[ch_cnt] <= cur_bit;
      ch_cnt          <= last ? '0 : ch_cnt + 1'b1;
    end
  end

  // Word FIFO storage, pointers and occupancy
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky record that a completed word was lost to a full FIFO
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)   overflow_out <= 1'b0;
    else if (drop) overflow_out <= 1'b1;
  end
endmodule

// File: tb/tb_psum_binarizer.sv
// Directed bench for psum_binarizer with a reference model and scoreboard.
module tb_psum_binarizer;
  localparam int W = 14, O_CH = 6, DEPTH = 2;

  logic            clk_in = 1'b0, rst_in = 1'b0;
  logic            psum_valid_in = 1'b0, frame_clr_in = 1'b0, thr_load_in = 1'b0, out_ready = 1'b0;
  logic [W-1:0]    psum_in = '0, thr_data_in = '0;
  logic            out_valid, overflow_out;
  logic [O_CH-1:0] out_bits;

  psum_binarizer #(.WIDTH(W), .O_CH(O_CH), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .psum_valid_in(psum_valid_in), .psum_in(psum_in),
    .frame_clr_in(frame_clr_in), .thr_load_in(thr_load_in), .thr_data_in(thr_data_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits), .overflow_out(overflow_out)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0, n_fail = 0;
  int m_thr[O_CH];
  int m_ch, m_ptr;
  logic [O_CH-1:0] m_part;
  logic [O_CH-1:0] sbq[$];
  bit m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < O_CH; i++) m_thr[i] = 0;
    m_ch = 0; m_ptr = 0; m_part = '0; m_ovf = 0;
    sbq.delete();
  endtask

  // One clock cycle: check outputs at the negedge, drive inputs, advance model
  task automatic cyc(input bit v, input int ps, input bit clr, input bit ld, input int th, input bit rdy);
    bit pop, push, b;
    logic [O_CH-1:0] w;
    chk("out_valid", {31'd0, out_valid}, {31'd0, sbq.size() != 0});
    chk("overflow", {31'd0, overflow_out}, {31'd0, m_ovf});
    pop = (sbq.size() != 0) && rdy;
    if (pop) chk("out_bits", {26'd0, out_bits}, {26'd0, sbq[0]});
    psum_valid_in = v; psum_in = W'(ps); frame_clr_in = clr;
    thr_load_in = ld; thr_data_in = W'(th); out_ready = rdy;
    push = 0; w = '0;
    if (clr) begin
      m_ch = 0; m_part = '0;
    end else if (v) begin
      b = (ps >= m_thr[m_ch]);
      m_part[m_ch] = b;
      if (m_ch == O_CH - 1) begin push = 1; w = m_part; m_ch = 0; end
      else m_ch++;
    end
    if (ld) begin m_thr[m_ptr] = th; m_ptr = (m_ptr + 1) % O_CH; end
    if (pop) void'(sbq.pop_front());
    if (push) begin
      if (sbq.size() < DEPTH) sbq.push_back(w);
      else m_ovf = 1;
    end
    @(posedge clk_in); @(negedge clk_in);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, rdy);
  endtask

  task automatic load6(input int t0, t1, t2, t3, t4, t5);
    int t[O_CH];
    t = '{t0, t1, t2, t3, t4, t5};
    for (int i = 0; i < O_CH; i++) cyc(0, 0, 0, 1, t[i], 0);
  endtask

  // Feeds a full word; out_ready is raised only on the final psum when rdy_last is set
  task automatic word6(input int p0, p1, p2, p3, p4, p5, input bit rdy_last);
    int p[O_CH];
    p = '{p0, p1, p2, p3, p4, p5};
    for (int i = 0; i < O_CH; i++) cyc(1, p[i], 0, 0, 0, (i == O_CH - 1) ? rdy_last : 1'b0);
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (2) @(negedge clk_in);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_bits", {26'd0, out_bits}, 32'd0);
    chk("rst_ovf", {31'd0, overflow_out}, 32'd0);
    rst_in = 1'b1;
    @(negedge clk_in);

    // 1: mixed thresholds, signed edges and equality -> 6'b011101
    load6(0, 5, -3, 100, -8192, 8191);
    word6(0, 4, -3, 101, -8192, 8190, 0);
    chk("t1_word_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_word_bits", {26'd0, out_bits}, 32'b011101);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t1_popped", {31'd0, out_valid}, 32'd0);

    // 3: full FIFO with a pop on the same edge as a new push -> no drop
    load6(0, 0, 0, 0, 0, 0);
    word6(1, 1, 1, 1, 1, 1, 0);
    word6(-1, -1, -1, -1, -1, -1, 0);
    word6(1, -1, 1, -1, 1, -1, 1);
    chk("t3_no_ovf", {31'd0, overflow_out}, 32'd0);
    idle(1, 0);
    idle(3, 1);

    // 5: same-cycle threshold load on channel 2 uses the old threshold
    load6(0, 0, 10, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 20, 0, 1, 50, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("t5_old_thr", {26'd0, out_bits}, 32'b111111);
    idle(1, 1);
    word6(0, 0, 20, 0, 0, 0, 0);
    chk("t5_new_thr", {26'd0, out_bits}, 32'b111011);
    idle(2, 1);

    // 4: frame clear mid-word discards the partial and the clear-cycle psum
    load6(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    word6(-1, 1, -1, 1, -1, -1, 0);
    chk("t4_fresh", {26'd0, out_bits}, 32'b001010);
    idle(3, 1);

    // 2: overflow with out_ready held low, then drain exactly two words
    word6(1, 1, 1, 1, 1, 1, 0);
    word6(-1, -1, -1, -1, -1, -1, 0);
    word6(1, 1, 1, 1, 1, 1, 0);
    chk("t2_ovf", {31'd0, overflow_out}, 32'd1);
    idle(2, 0);
    idle(4, 1);

    // 6: asynchronous reset mid-word with a full FIFO
    word6(1, 1, 1, 1, 1, 1, 0);
    word6(1, 1, 1, 1, 1, 1, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    #2 rst_in = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_ovf", {31'd0, overflow_out}, 32'd0);
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    word6(-1, 0, 1, -5, 5, 0, 0);
    chk("t6_after_rst", {26'd0, out_bits}, 32'b110110);
    idle(3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
